// File: rtl/verify_pkg.sv
// Shared definitions for the verification datapath:
// sequencer states and default sizes used by control FSM and memory.
package verify_pkg;

   localparam int DEPTH_DEF  = 16;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/verify_sequencer_rise_detect.sv
// Registered rising-edge detector for a single level input.
// Output is high in the cycle the input is high after being low.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise
);

   logic prev;

   // remember last cycle's level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev <= 1'b0;
      else     prev <= sig;
   end

   assign rise = sig & ~prev;

endmodule

// File: rtl/verify_sequencer.sv
// Sweeps the verification memory, compares each word against the
// latched key, counts matches and records the first matching address.
module verify_sequencer
   import verify_pkg::*;
#(
   parameter  int DEPTH  = DEPTH_DEF,
   parameter  int DATA_W = DATA_W_DEF,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_verification,
   input  logic [DATA_W-1:0] key,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              final_analysis,
   output logic [ADDR_W:0]   match_count,
   output logic              match_found,
   output logic [ADDR_W-1:0] first_match_addr
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t              state;
   logic                start_edge;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   key_q;
   logic                rd_valid;
   logic [ADDR_W-1:0]   cmp_addr;
   logic                hit;

   rise_detect u_start (
      .clk  (clk),
      .rst  (rst),
      .sig  (start_verification),
      .rise (start_edge)
   );

   assign mem_addr = addr;
   assign hit      = rd_valid && (mem_rdata == key_q);

   // read data returns one cycle after the request; track its address
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid <= 1'b0;
         cmp_addr <= '0;
      end else begin
         rd_valid <= mem_rd_en;
         cmp_addr <= addr;
      end
   end

   // sweep sequencing, result accumulation and completion pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         addr             <= '0;
         key_q            <= '0;
         mem_rd_en        <= 1'b0;
         busy             <= 1'b0;
         final_analysis   <= 1'b0;
         match_count      <= '0;
         match_found      <= 1'b0;
         first_match_addr <= '0;
      end else begin
         if (hit) begin
            match_count <= match_count + 1'b1;
            if (!match_found) begin
               first_match_addr <= cmp_addr;
               match_found      <= 1'b1;
            end
         end
         unique case (state)
            IDLE: begin
               final_analysis <= 1'b0;
               if (start_edge) begin
                  state            <= SCAN;
                  key_q            <= key;
                  addr             <= '0;
                  mem_rd_en        <= 1'b1;
                  busy             <= 1'b1;
                  match_count      <= '0;
                  match_found      <= 1'b0;
                  first_match_addr <= '0;
               end
            end
            SCAN: begin
               if (addr == LAST) begin
                  state     <= DRAIN;
                  addr      <= '0;
                  mem_rd_en <= 1'b0;
               end else begin
                  addr <= addr + 1'b1;
               end
            end
            DRAIN: begin
               state          <= DONE;
               busy           <= 1'b0;
               final_analysis <= 1'b1;
            end
            DONE: begin
               state          <= IDLE;
               final_analysis <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_verify_sequencer.sv
// Randomised and directed bench for verify_sequencer with a
// cycle-level behavioural model and literal result checks.
module tb_verify_sequencer;

   localparam int DEPTH = 16;
   localparam int DW    = 8;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_verification = 1'b0;
   logic [DW-1:0] key = '0;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata = '0;
   logic          busy;
   logic          final_analysis;
   logic [AW:0]   match_count;
   logic          match_found;
   logic [AW-1:0] first_match_addr;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem  [DEPTH];
   logic [DW-1:0] snap [DEPTH];

   int   phase = -1;
   bit   m_prev = 1'b0;
   bit   have_run = 1'b0;
   bit   st_edge;
   logic [DW-1:0] m_key = '0;
   int   cyc = 0;
   int   fa_seen = 0;
   int   fa_cyc = 0;
   int   first_rd_cyc = 0;
   bit   last_rd = 1'b0;

   verify_sequencer #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
      .clk                (clk),
      .rst                (rst),
      .start_verification (start_verification),
      .key                (key),
      .mem_rd_en          (mem_rd_en),
      .mem_addr           (mem_addr),
      .mem_rdata          (mem_rdata),
      .busy               (busy),
      .final_analysis     (final_analysis),
      .match_count        (match_count),
      .match_found        (match_found),
      .first_match_addr   (first_match_addr)
   );

   always #5 clk = ~clk;

   // synchronous-read memory
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   // results over addresses 0..lim of the snapshot
   function automatic void model_res(input int lim,
                                     output int cnt,
                                     output int first);
      cnt = 0;
      first = 0;
      for (int a = 0; a < DEPTH; a++) begin
         if (a <= lim && snap[a] == m_key) begin
            if (cnt == 0) first = a;
            cnt++;
         end
      end
   endfunction

   // model: run phase counted in cycles since the accepted start edge
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         phase    = -1;
         m_prev   = 1'b0;
         have_run = 1'b0;
         m_key    = '0;
      end else begin
         cyc++;
         st_edge = start_verification && !m_prev;
         m_prev  = start_verification;
         if (phase < 0) begin
            if (st_edge) begin
               phase    = 0;
               m_key    = key;
               have_run = 1'b1;
               for (int a = 0; a < DEPTH; a++) snap[a] = mem[a];
            end
         end else if (phase == DEPTH + 1) begin
            phase = -1;
         end else begin
            phase++;
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      int p, lim, c, f;
      bit e_rd, e_busy, e_fa;
      int e_addr;
      if (!rst) begin
         p      = phase;
         e_rd   = (p >= 0) && (p < DEPTH);
         e_addr = e_rd ? p : 0;
         e_busy = (p >= 0) && (p <= DEPTH);
         e_fa   = (p == DEPTH + 1);
         if (p >= 0)       lim = p - 2;
         else if (have_run) lim = DEPTH - 1;
         else               lim = -1;
         model_res(lim, c, f);
         chk("mem_rd_en", int'(mem_rd_en), int'(e_rd));
         chk("mem_addr", int'(mem_addr), e_addr);
         chk("busy", int'(busy), int'(e_busy));
         chk("final_analysis", int'(final_analysis), int'(e_fa));
         chk("match_count", int'(match_count), c);
         chk("match_found", int'(match_found), int'(c != 0));
         chk("first_match_addr", int'(first_match_addr), f);
         if (final_analysis) begin
            fa_seen++;
            fa_cyc = cyc;
         end
         if (mem_rd_en && !last_rd) first_rd_cyc = cyc;
         last_rd = mem_rd_en;
      end
   end

   task automatic pulse(input logic [DW-1:0] k, input int hold);
      @(negedge clk);
      start_verification = 1'b1;
      key = k;
      repeat (hold) @(negedge clk);
      start_verification = 1'b0;
   endtask

   task automatic wait_done(input int n0, input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 80 && !ok; i++) begin
         @(negedge clk);
         #1;
         if (fa_seen > n0) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no final_analysis expected one", nm);
      end
      @(negedge clk);
      #1;
   endtask

   task automatic run(input logic [DW-1:0] k, input int hold,
                      input string nm);
      int n0;
      n0 = fa_seen;
      pulse(k, hold);
      wait_done(n0, nm);
   endtask

   task automatic res(input string nm, input int c, input int f);
      chk({nm, "_count"}, int'(match_count), c);
      chk({nm, "_found"}, int'(match_found), int'(c != 0));
      chk({nm, "_first"}, int'(first_match_addr), f);
   endtask

   initial begin
      int n0;
      for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a);
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rd_en", int'(mem_rd_en), 0);
      chk("rst_fa", int'(final_analysis), 0);
      chk("rst_count", int'(match_count), 0);
      chk("rst_first", int'(first_match_addr), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // word = address, key 5
      run(8'd5, 1, "t1");
      chk("t1_latency", fa_cyc - first_rd_cyc, DEPTH + 1);
      res("t1", 1, 5);

      // three scattered matches
      for (int a = 0; a < DEPTH; a++) mem[a] = 8'h00;
      mem[3] = 8'hAA; mem[7] = 8'hAA; mem[12] = 8'hAA;
      run(8'hAA, 2, "t2");
      res("t2", 3, 3);

      // all match, then none
      for (int a = 0; a < DEPTH; a++) mem[a] = 8'h3C;
      run(8'h3C, 1, "t3a");
      res("t3a", 16, 0);
      run(8'h11, 1, "t3b");
      res("t3b", 0, 0);

      // long start level, retrigger attempt and key change mid-run
      for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a);
      n0 = fa_seen;
      pulse(8'd7, 40);
      repeat (5) @(negedge clk);
      chk("t4_held_pulses", fa_seen - n0, 1);
      res("t4_held", 1, 7);
      n0 = fa_seen;
      pulse(8'd5, 1);
      repeat (3) @(negedge clk);
      start_verification = 1'b1;
      key = 8'd9;
      @(negedge clk);
      start_verification = 1'b0;
      repeat (25) @(negedge clk);
      chk("t4_retrig_pulses", fa_seen - n0, 1);
      res("t4_key", 1, 5);

      // asynchronous abort mid-scan
      n0 = fa_seen;
      pulse(8'd2, 1);
      repeat (8) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("t5_busy", int'(busy), 0);
      chk("t5_rd_en", int'(mem_rd_en), 0);
      chk("t5_addr", int'(mem_addr), 0);
      chk("t5_count", int'(match_count), 0);
      chk("t5_found", int'(match_found), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      chk("t5_no_pulse", fa_seen - n0, 0);
      run(8'd2, 1, "t5_fresh");
      res("t5_fresh", 1, 2);

      // random contents, keys, hold lengths and gaps
      for (int r = 0; r < 8; r++) begin
         for (int a = 0; a < DEPTH; a++)
            mem[a] = DW'($urandom_range(0, 3));
         run(DW'($urandom_range(0, 3)), $urandom_range(1, 6), "rand");
         repeat ($urandom_range(0, 4)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
